// File: rtl/slowctrl_pkg.sv
// Shared slow-control word layout: type bits, field offsets, word builders.
// Used by both the command decoder and the reply packer.
package slowctrl_pkg;

  localparam int NUM_SCA = 3;

  localparam int IC_TYPE_BIT  = 159;
  localparam int SCA_HDR_BIT  = 158;
  localparam int SCA_TYPE_BIT = 79;
  localparam int IDX_LSB      = 152;

  localparam int IC_CNT_MSB = 156;
  localparam int IC_CNT_LSB = 152;
  localparam int GBTX_LSB   = 144;
  localparam int REGA_LSB   = 128;

  localparam int SCA_ADDR_LSB = 64;
  localparam int SCA_TRID_LSB = 56;
  localparam int SCA_CHAN_LSB = 48;
  localparam int SCA_LEN_LSB  = 40;
  localparam int SCA_ERR_LSB  = 32;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  trans_id;
    logic [7:0]  channel;
    logic [7:0]  len;
    logic [7:0]  error;
    logic [31:0] data;
  } sca_fields_t;

  function automatic logic [159:0] sca_word(
    input sca_fields_t f,
    input logic [1:0]  idx
  );
    logic [159:0] w;
    w = '0;
    w[SCA_HDR_BIT] = 1'b1;
    w[IDX_LSB +: 2] = idx;
    w[SCA_TYPE_BIT] = 1'b1;
    w[SCA_ADDR_LSB +: 8] = f.addr;
    w[SCA_TRID_LSB +: 8] = f.trans_id;
    w[SCA_CHAN_LSB +: 8] = f.channel;
    w[SCA_LEN_LSB +: 8] = f.len;
    w[SCA_ERR_LSB +: 8] = f.error;
    w[31:0] = f.data;
    return w;
  endfunction

  function automatic logic [159:0] ic_word(
    input logic [4:0]   cnt,
    input logic [7:0]   gbtx,
    input logic [15:0]  reg_addr,
    input logic [127:0] bytes
  );
    logic [159:0] w;
    w = '0;
    w[IC_TYPE_BIT] = 1'b1;
    w[IC_CNT_MSB:IC_CNT_LSB] = cnt;
    w[GBTX_LSB +: 8] = gbtx;
    w[REGA_LSB +: 16] = reg_addr;
    w[127:0] = bytes;
    return w;
  endfunction

endpackage

// File: rtl/sca_reply_latch.sv
// Holds the latest reply from one SCA until the packer emits it.
// Overwriting an unemitted reply raises a sticky overrun flag.
module sca_reply_latch
  import slowctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  sca_fields_t fields_i,
  input  logic        clear_i,
  output sca_fields_t fields_o,
  output logic        pending_o,
  output logic        overrun_o
);

  sca_fields_t fields_q;
  logic        pending_q;
  logic        overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fields_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (capture_i) fields_q <= fields_i;
      // capture wins over a same-cycle clear
      pending_q <= capture_i | (pending_q & ~clear_i);
      if (capture_i && pending_q && !clear_i) overrun_q <= 1'b1;
    end
  end

  assign fields_o  = fields_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/reply_assemble.sv
// Packs IC read-back bytes and SCA replies into 160-bit data-back words.
// Fixed priority IC > SCA0 > SCA1 > SCA2; one word per EMIT.
module reply_assemble
  import slowctrl_pkg::*;
#(
  parameter int MAX_BYTES     = 16,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_rx_done,
  input  logic [7:0]   ic_rx_nbytes,
  input  logic [7:0]   ic_rx_gbtx_addr,
  input  logic [15:0]  ic_rx_reg_addr,
  input  logic         ic_rfifo_empty,
  output logic         ic_rfifo_rd,
  input  logic [7:0]   ic_rfifo_data,
  input  logic [2:0]   rx_reply_received_i,
  input  logic [23:0]  rx_address,
  input  logic [23:0]  rx_transID,
  input  logic [23:0]  rx_channel,
  input  logic [23:0]  rx_len,
  input  logic [23:0]  rx_error,
  input  logic [95:0]  rx_data,
  input  logic         data_back_full,
  output logic [159:0] data_back,
  output logic         data_back_wr,
  output logic         ic_overrun,
  output logic [2:0]   sca_overrun
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DRAIN     = 2'd1;
  localparam logic [1:0] WAIT_LAST = 2'd2;
  localparam logic [1:0] EMIT      = 2'd3;

  localparam logic [4:0] MAXB = 5'(MAX_BYTES);
  localparam logic [7:0] TMO  = 8'(DRAIN_TIMEOUT);

  logic [1:0]   state_q, state_d;
  logic         ic_pend_q, ic_pend_d;
  logic [7:0]   nbytes_q, nbytes_d;
  logic [7:0]   gbtx_q, gbtx_d;
  logic [15:0]  rega_q, rega_d;
  logic [7:0]   rem_q, rem_d;
  logic [4:0]   slot_q, slot_d;
  logic [7:0]   tmo_q, tmo_d;
  logic [127:0] bytes_q, bytes_d;
  logic         rd_q;
  logic         src_ic_q, src_ic_d;
  logic [1:0]   idx_q, idx_d;
  logic [159:0] db_q, db_d;
  logic         ovr_q, ovr_d;

  sca_fields_t        f_in [NUM_SCA];
  sca_fields_t        f_q  [NUM_SCA];
  logic [NUM_SCA-1:0] pend;
  logic [NUM_SCA-1:0] clr;
  logic [1:0]         sca_sel;
  logic [7:0]         rem_eff;
  logic               rd;
  logic               wr;

  for (genvar i = 0; i < NUM_SCA; i++) begin : g_sca
    assign f_in[i] = {rx_address[8*i +: 8],
                      rx_transID[8*i +: 8],
                      rx_channel[8*i +: 8],
                      rx_len[8*i +: 8],
                      rx_error[8*i +: 8],
                      rx_data[32*i +: 32]};
    assign clr[i] = wr && !src_ic_q && (idx_q == 2'(i));

    sca_reply_latch u_latch (
      .clk       (clk),
      .rst       (rst),
      .capture_i (rx_reply_received_i[i]),
      .fields_i  (f_in[i]),
      .clear_i   (clr[i]),
      .fields_o  (f_q[i]),
      .pending_o (pend[i]),
      .overrun_o (sca_overrun[i])
    );
  end

  always_comb begin
    sca_sel = '0;
    for (int i = NUM_SCA - 1; i >= 0; i--) begin
      if (pend[i]) sca_sel = 2'(i);
    end
  end

  // popping starts in IDLE so the first byte is requested right after done
  assign rem_eff = (state_q == IDLE) ? nbytes_q : rem_q;
  assign rd = ((state_q == IDLE && ic_pend_q) || state_q == DRAIN)
              && !ic_rfifo_empty && rem_eff != 8'd0;
  assign wr = (state_q == EMIT) && !data_back_full;

  always_comb begin
    state_d  = state_q;
    ic_pend_d = ic_pend_q;
    nbytes_d = nbytes_q;
    gbtx_d   = gbtx_q;
    rega_d   = rega_q;
    rem_d    = rem_q;
    slot_d   = slot_q;
    tmo_d    = tmo_q;
    bytes_d  = bytes_q;
    src_ic_d = src_ic_q;
    idx_d    = idx_q;
    db_d     = db_q;
    ovr_d    = ovr_q;

    if (wr && src_ic_q) ic_pend_d = 1'b0;
    if (ic_rx_done) begin
      if (ic_pend_q || state_q == DRAIN) begin
        ovr_d = 1'b1;
      end else begin
        ic_pend_d = 1'b1;
        nbytes_d  = ic_rx_nbytes;
        gbtx_d    = ic_rx_gbtx_addr;
        rega_d    = ic_rx_reg_addr;
      end
    end

    if (state_q == IDLE) begin
      slot_d  = '0;
      bytes_d = '0;
    end else if (rd_q) begin
      if (slot_q < MAXB) begin
        bytes_d[{slot_q[3:0], 3'b000} +: 8] = ic_rfifo_data;
        slot_d = slot_q + 5'd1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ic_pend_q) begin
          src_ic_d = 1'b1;
          tmo_d    = '0;
          if (nbytes_q == 8'd0) begin
            state_d = EMIT;
            db_d = ic_word(5'd0, gbtx_q, rega_q, '0);
          end else begin
            rem_d = nbytes_q - {7'd0, rd};
            state_d = (rd && nbytes_q == 8'd1) ? WAIT_LAST : DRAIN;
          end
        end else if (|pend) begin
          src_ic_d = 1'b0;
          idx_d    = sca_sel;
          state_d  = EMIT;
          db_d     = sca_word(f_q[sca_sel], sca_sel);
        end
      end
      DRAIN: begin
        if (rd) begin
          rem_d = rem_q - 8'd1;
          tmo_d = '0;
          if (rem_q == 8'd1) state_d = WAIT_LAST;
        end else if (tmo_q == TMO) begin
          state_d = WAIT_LAST;
          ovr_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WAIT_LAST: begin
        state_d = EMIT;
        db_d = ic_word(slot_d, gbtx_q, rega_q, bytes_d);
      end
      EMIT: begin
        if (wr) begin
          state_d = IDLE;
        end else if (!src_ic_q) begin
          // track a stalled SCA latch so an overwrite emits the newer reply
          db_d = sca_word(f_q[idx_q], idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ic_pend_q <= 1'b0;
      nbytes_q  <= '0;
      gbtx_q    <= '0;
      rega_q    <= '0;
      rem_q     <= '0;
      slot_q    <= '0;
      tmo_q     <= '0;
      bytes_q   <= '0;
      rd_q      <= 1'b0;
      src_ic_q  <= 1'b0;
      idx_q     <= '0;
      db_q      <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ic_pend_q <= ic_pend_d;
      nbytes_q  <= nbytes_d;
      gbtx_q    <= gbtx_d;
      rega_q    <= rega_d;
      rem_q     <= rem_d;
      slot_q    <= slot_d;
      tmo_q     <= tmo_d;
      bytes_q   <= bytes_d;
      rd_q      <= rd;
      src_ic_q  <= src_ic_d;
      idx_q     <= idx_d;
      db_q      <= db_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ic_rfifo_rd  = rd;
  assign data_back_wr = wr;
  assign data_back    = db_q;
  assign ic_overrun   = ovr_q;

endmodule

// File: tb/tb_reply_assemble.sv
// Scoreboard bench for reply_assemble: expected words queued at stimulus,
// checked at each data_back_wr together with the strobe cycle.
module tb_reply_assemble;

  localparam int DT = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_rx_done;
  logic [7:0]   ic_rx_nbytes;
  logic [7:0]   ic_rx_gbtx_addr;
  logic [15:0]  ic_rx_reg_addr;
  logic         fempty;
  logic         ic_rfifo_rd;
  logic [7:0]   fdata;
  logic [2:0]   rx_rcv;
  logic [23:0]  rx_address, rx_transID, rx_channel, rx_len, rx_error;
  logic [95:0]  rx_data;
  logic         full;
  logic [159:0] data_back;
  logic         data_back_wr;
  logic         ic_overrun;
  logic [2:0]   sca_overrun;

  reply_assemble #(.MAX_BYTES(16), .DRAIN_TIMEOUT(DT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ic_rx_done          (ic_rx_done),
    .ic_rx_nbytes        (ic_rx_nbytes),
    .ic_rx_gbtx_addr     (ic_rx_gbtx_addr),
    .ic_rx_reg_addr      (ic_rx_reg_addr),
    .ic_rfifo_empty      (fempty),
    .ic_rfifo_rd         (ic_rfifo_rd),
    .ic_rfifo_data       (fdata),
    .rx_reply_received_i (rx_rcv),
    .rx_address          (rx_address),
    .rx_transID          (rx_transID),
    .rx_channel          (rx_channel),
    .rx_len              (rx_len),
    .rx_error            (rx_error),
    .rx_data             (rx_data),
    .data_back_full      (full),
    .data_back           (data_back),
    .data_back_wr        (data_back_wr),
    .ic_overrun          (ic_overrun),
    .sca_overrun         (sca_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] w;
    int           lo;
    int           hi;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] fq[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt, rd_first, rd_last;

  always @(posedge clk) cyc <= cyc + 1;

  // IC read FIFO model: data valid the cycle after the pop
  always @(posedge clk) begin
    if (ic_rfifo_rd) begin
      fdata  <= fq.pop_front();
      fempty <= (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (ic_rfifo_rd) begin
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
      rd_cnt++;
    end
    if (data_back_wr) begin
      wr_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write data_back=%h", data_back);
      end else begin
        e = sb.pop_front();
        if (data_back !== e.w) begin
          n_fail++;
          $display("FAIL word got=%h exp=%h", data_back, e.w);
        end
        if (e.lo >= 0) begin
          n_checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL wr_cycle got=%0d exp=%0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end
    end
  end

  function automatic logic [159:0] exp_ic(logic [4:0] c, logic [7:0] g,
                                          logic [15:0] r, logic [127:0] b);
    return {1'b1, 2'b00, c, g, r, b};
  endfunction

  function automatic logic [159:0] exp_sca(logic [1:0] i, logic [7:0] a,
      logic [7:0] t, logic [7:0] ch, logic [7:0] l, logic [7:0] er,
      logic [31:0] d);
    return {2'b01, 4'b0000, i, 72'h0, 1'b1, 7'h0, a, t, ch, l, er, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(logic [159:0] w, int lo, int hi);
    exp_t x;
    x.w = w; x.lo = lo; x.hi = hi;
    sb.push_back(x);
  endtask

  task automatic set_lane(int i, logic [7:0] a, logic [7:0] t, logic [7:0] ch,
                          logic [7:0] l, logic [7:0] er, logic [31:0] d);
    rx_address[8*i +: 8] = a;
    rx_transID[8*i +: 8] = t;
    rx_channel[8*i +: 8] = ch;
    rx_len[8*i +: 8]     = l;
    rx_error[8*i +: 8]   = er;
    rx_data[32*i +: 32]  = d;
  endtask

  task automatic wait_drain(int budget, string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout pending=%0d exp=0", name, sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_rx_done = 1'b0; ic_rx_nbytes = '0;
    ic_rx_gbtx_addr = '0; ic_rx_reg_addr = '0;
    rx_rcv = '0; full = 1'b0;
    rx_address = 24'hC3C2C1; rx_transID = 24'hD3D2D1;
    rx_channel = 24'hE3E2E1; rx_len = 24'hF3F2F1;
    rx_error = 24'h0A0B0C; rx_data = {3{32'h5555AAAA}};
    fq.delete(); fempty = 1'b1;
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 5;
    if (data_back !== '0) begin
      n_fail++; $display("FAIL rst_data got=%h exp=0", data_back);
    end
    if (data_back_wr !== 1'b0) begin
      n_fail++; $display("FAIL rst_wr got=%b exp=0", data_back_wr);
    end
    if (ic_rfifo_rd !== 1'b0) begin
      n_fail++; $display("FAIL rst_rd got=%b exp=0", ic_rfifo_rd);
    end
    if (ic_overrun !== 1'b0) begin
      n_fail++; $display("FAIL rst_icovr got=%b exp=0", ic_overrun);
    end
    if (sca_overrun !== 3'b000) begin
      n_fail++; $display("FAIL rst_scaovr got=%b exp=0", sca_overrun);
    end
  endtask

  task automatic test_sca_reply();
    int t;
    set_lane(1, 8'h00, 8'h05, 8'h14, 8'h04, 8'h00, 32'hDEADBEEF);
    t = cyc;
    push_exp(exp_sca(2'd1, 8'h00, 8'h05, 8'h14, 8'h04, 8'h00, 32'hDEADBEEF),
             t + 2, t + 2);
    rx_rcv = 3'b010;
    step();
    rx_rcv = '0;
    wait_drain(20, "sca1");
    n_checks++;
    if (sca_overrun !== 3'b000) begin
      n_fail++; $display("FAIL sca1_ovr got=%b exp=000", sca_overrun);
    end
  endtask

  task automatic test_ic_read3();
    int t;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    fempty = 1'b0;
    rd_cnt = 0; rd_first = -1;
    t = cyc;
    push_exp(exp_ic(5'd3, 8'h70, 16'h01AB, {104'h0, 24'h332211}), t + 5, t + 5);
    ic_rx_done = 1'b1; ic_rx_nbytes = 8'd3;
    ic_rx_gbtx_addr = 8'h70; ic_rx_reg_addr = 16'h01AB;
    step();
    ic_rx_done = 1'b0;
    wait_drain(30, "ic3");
    n_checks += 4;
    if (rd_cnt !== 3) begin
      n_fail++; $display("FAIL ic3_pops got=%0d exp=3", rd_cnt);
    end
    if (rd_first !== t + 1) begin
      n_fail++; $display("FAIL ic3_first_rd got=%0d exp=%0d", rd_first, t + 1);
    end
    if (rd_last !== t + 3) begin
      n_fail++; $display("FAIL ic3_last_rd got=%0d exp=%0d", rd_last, t + 3);
    end
    if (ic_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ic3_ovr got=%b exp=0", ic_overrun);
    end
  endtask

  task automatic test_ic_overflow();
    int t;
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 20; k++) fq.push_back(8'(k + 1));
    for (int k = 0; k < 16; k++) b[8*k +: 8] = 8'(k + 1);
    fempty = 1'b0;
    rd_cnt = 0;
    t = cyc;
    push_exp(exp_ic(5'd16, 8'h21, 16'hCAFE, b), t + 22, t + 22);
    ic_rx_done = 1'b1; ic_rx_nbytes = 8'd20;
    ic_rx_gbtx_addr = 8'h21; ic_rx_reg_addr = 16'hCAFE;
    step();
    ic_rx_done = 1'b0;
    wait_drain(60, "ic20");
    n_checks += 2;
    if (rd_cnt !== 20) begin
      n_fail++; $display("FAIL ic20_pops got=%0d exp=20", rd_cnt);
    end
    if (ic_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ic20_ovr got=%b exp=1", ic_overrun);
    end
  endtask

  task automatic test_timeout();
    int t;
    do_reset();
    fq.push_back(8'hA1); fq.push_back(8'hA2);
    fempty = 1'b0;
    rd_cnt = 0;
    t = cyc;
    push_exp(exp_ic(5'd2, 8'h12, 16'h3456, {112'h0, 16'hA2A1}),
             t + 2 + DT, t + 5 + DT);
    ic_rx_done = 1'b1; ic_rx_nbytes = 8'd4;
    ic_rx_gbtx_addr = 8'h12; ic_rx_reg_addr = 16'h3456;
    step();
    ic_rx_done = 1'b0;
    wait_drain(DT + 50, "ic_tmo");
    n_checks += 2;
    if (rd_cnt !== 2) begin
      n_fail++; $display("FAIL tmo_pops got=%0d exp=2", rd_cnt);
    end
    if (ic_overrun !== 1'b1) begin
      n_fail++; $display("FAIL tmo_ovr got=%b exp=1", ic_overrun);
    end
  endtask

  task automatic test_simultaneous();
    int t, w0;
    do_reset();
    set_lane(0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 32'h10203040);
    set_lane(2, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 32'hA0B0C0D0);
    t = cyc;
    w0 = wr_cnt;
    push_exp(exp_ic(5'd0, 8'h5A, 16'hBEEF, 128'h0), t + 2, t + 2);
    push_exp(exp_sca(2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 32'h10203040),
             t + 4, t + 4);
    push_exp(exp_sca(2'd2, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 32'hA0B0C0D0),
             t + 6, t + 6);
    ic_rx_done = 1'b1; ic_rx_nbytes = 8'd0;
    ic_rx_gbtx_addr = 8'h5A; ic_rx_reg_addr = 16'hBEEF;
    rx_rcv = 3'b101;
    step();
    ic_rx_done = 1'b0; rx_rcv = '0;
    wait_drain(30, "simul");
    n_checks++;
    if (wr_cnt - w0 !== 3) begin
      n_fail++; $display("FAIL simul_writes got=%0d exp=3", wr_cnt - w0);
    end
  endtask

  task automatic test_back_pressure();
    int t, w0;
    do_reset();
    full = 1'b1;
    w0 = wr_cnt;
    t = cyc;
    set_lane(0, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 32'h11111111);
    rx_rcv = 3'b001;
    step();
    rx_rcv = '0;
    repeat (3) step();
    set_lane(0, 8'hBB, 8'h07, 8'h08, 8'h09, 8'h0E, 32'h22222222);
    rx_rcv = 3'b001;
    step();
    rx_rcv = '0;
    while (cyc < t + 10) step();
    push_exp(exp_sca(2'd0, 8'hBB, 8'h07, 8'h08, 8'h09, 8'h0E, 32'h22222222),
             cyc, cyc);
    full = 1'b0;
    wait_drain(20, "bp");
    repeat (4) step();
    n_checks += 2;
    if (wr_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL bp_writes got=%0d exp=1", wr_cnt - w0);
    end
    if (sca_overrun !== 3'b001) begin
      n_fail++; $display("FAIL bp_ovr got=%b exp=001", sca_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_sca_reply();
    test_ic_read3();
    test_ic_overflow();
    test_timeout();
    test_simultaneous();
    test_back_pressure();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/reply_assemble.md
# reply_assemble

Return-path packer for the slow-control bridge. Collects lpGBT IC read-back bytes and GBT-SCA replies from up to three SCAs, and formats each as one 160-bit word. Pushes each word into the upstream data-back FIFO toward the host/UART link. It is the response-side counterpart of the 160-bit command decoder: the type-bit positions and field order mirror the command word.

## Interface
Parameters:
- MAX_BYTES, 16: maximum IC payload bytes per word.
- DRAIN_TIMEOUT, 255: idle cycles allowed while waiting on an empty IC FIFO mid-drain.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ic_rx_done  in  1  pulse: IC read transaction finished.
- ic_rx_nbytes  in  8  bytes requested; sampled with ic_rx_done.
- ic_rx_gbtx_addr  in  8  GBTx address; sampled with ic_rx_done.
- ic_rx_reg_addr  in  16  register address; sampled with ic_rx_done.
- ic_rfifo_empty  in  1  IC read FIFO empty.
- ic_rfifo_rd  out  1  IC read FIFO pop. Standard FIFO: data is valid on the cycle after the pop.
- ic_rfifo_data  in  8  IC read FIFO data.
- rx_reply_received_i  in  3  per-SCA reply pulse.
- rx_address, rx_transID, rx_channel, rx_len, rx_error  in  24 each  three 8-bit lanes; lane i = [8i+7:8i].
- rx_data  in  96  three 32-bit lanes.
- data_back_full  in  1  upstream FIFO full.
- data_back  out  160  packed reply word.
- data_back_wr  out  1  one-cycle write strobe.
- ic_overrun  out  1  sticky: IC data truncated, timed out, or a done pulse was lost.
- sca_overrun  out  3  sticky per SCA: reply overwritten before it was emitted.

## Operation
- Reset: all outputs 0; all pending flags 0; FSM = IDLE.
- SCA capture:
  - rx_reply_received_i[i] registers lane i fields into latch i and sets pending[i].
  - If pending[i] is already set, the fields are overwritten and sca_overrun[i] is set.
  - A capture and a clear of pending[i] in the same cycle leaves pending[i] = 1 with the new data.
- IC capture:
  - ic_rx_done latches the address and count fields and sets ic_pending.
  - A done pulse while ic_pending or DRAIN is active is dropped and sets ic_overrun.
- FSM states: IDLE, DRAIN, WAIT_LAST, EMIT.
  - IDLE: selects by fixed priority IC > SCA0 > SCA1 > SCA2.
    - IC selected with count 0 → EMIT.
    - IC selected with count > 0 → DRAIN.
    - SCA selected → EMIT.
  - DRAIN:
    - Assert ic_rfifo_rd whenever the FIFO is not empty and remaining > 0. The byte popped on one cycle is written on the next cycle to slot k (k = pops so far).
    - Bytes beyond MAX_BYTES are still popped but discarded, and ic_overrun is set.
    - Remaining reaches 0 → WAIT_LAST.
    - Timeout counter: reset on each pop, incremented while empty. At DRAIN_TIMEOUT → WAIT_LAST, set ic_overrun; the count field reports the bytes actually received.
  - WAIT_LAST: captures the final byte → EMIT.
  - EMIT:
    - Hold data_back stable.
    - Assert data_back_wr for exactly one cycle, on the first cycle data_back_full = 0.
    - Then clear the source's pending flag → IDLE.
- IC word layout:
  - [159] = 1; [158:157] = 0; [156:152] = received count (0..16).
  - [151:144] = GBTx addr; [143:128] = reg addr.
  - [127:0] = bytes; byte k at [8k+7:8k]; unused bytes 0.
- SCA word layout:
  - [159:158] = 01; [153:152] = SCA index; [79] = 1.
  - [71:64] = address; [63:56] = transID; [55:48] = channel; [47:40] = len; [39:32] = error; [31:0] = data.
  - All other bits 0.
- Counters: 8-bit remaining count, 5-bit slot index, 8-bit timeout counter. The slot index saturates at MAX_BYTES.

## Timing
- SCA latency, with FSM idle and FIFO not full: pulse at cycle t → data_back_wr at t+2.
- IC latency, with a non-empty FIFO: done at t → ic_rfifo_rd high t+1..t+N, data_back_wr at t+N+2.
- IC latency for N = 0: data_back_wr at t+2.
- data_back is stable from EMIT entry through the strobe; it holds its value after the strobe.
- Back-pressure: data_back_full only stalls EMIT. Captures continue meanwhile, and may set overrun flags.

## Structure
- Shared package slowctrl_pkg holds:
  - type bit positions 159 and 79;
  - SCA field offsets;
  - IC count field range [156:152];
  - the constant NUM_SCA = 3.
  The command decoder uses the same package.
- Sub-module sca_reply_latch: capture registers, pending flag and overrun flag for one SCA. Instantiated three times.

## Test plan
- SCA1 reply: addr 0x00, transID 0x05, channel 0x14, len 4, error 0, data 0xDEADBEEF. Expect data_back_wr at t+2 and data_back[159:152] = 0x41, [79] = 1, [71:0] = 0x00_05_14_04_00_DEADBEEF.
- IC read, N = 3, FIFO holding 0x11, 0x22, 0x33, gbtx 0x70, reg 0x01AB. Expect ic_rfifo_rd asserted 3 cycles and data_back = {0x83, 0x70, 0x01AB, 104'h0, 0x332211}.
- IC read, N = 20. Expect 20 pops, count field 16, bytes 0..15 present, ic_overrun = 1.
- IC read, N = 4, only 2 bytes ever supplied. Expect emit DRAIN_TIMEOUT cycles after the last pop, count 2, ic_overrun = 1.
- Simultaneous ic_rx_done (N = 0) and SCA0 and SCA2 pulses. Expect three writes in order IC, SCA0, SCA2.
- data_back_full held high for 10 cycles with one reply pending. Expect exactly one write, in the first cycle after full falls. A second SCA0 pulse during the stall sets sca_overrun[0] and the newer data is emitted.
